// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency/period meter: FSM state
// encoding, default sizing constants and a saturating increment.
package freq_meter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned GATE_CYCLES_DEF = 50_000_000;
  localparam int unsigned CNT_W_DEF       = 32;

  // Wide enough for any counter width up to 64; callers cast to their own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v,
                                          input logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a delay flop; flags a rising edge of an
// asynchronous input as a single-cycle pulse in the clkin domain.
module sync_edge (
  input  logic clkin,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter (frequency) and edge-to-edge cycle counter (period) for
// an asynchronous square wave, with one-cycle valid strobes on each result.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             freq_ovf,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  localparam int unsigned      GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), 64'(CNT_MAX)));
  endfunction

  logic rise;

  sync_edge u_sync (
    .clkin (clkin),
    .rst_n (rst_n),
    .d     (sig_in),
    .rise  (rise)
  );

  state_e state_q, state_d;
  logic   armed_q, armed_d;
  logic   run;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // armed_q records that RUN has seen its first edge, so period strobes start
  // only once a full edge-to-edge interval has been timed.
  always_comb begin
    state_d = state_q;
    armed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        armed_d = armed_q | rise;
        if (!en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run = (state_q == ST_RUN);
  end

  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             edge_sat_q, edge_sat_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             freq_ovf_q, freq_ovf_d;
  logic             freq_valid_q, freq_valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;

  logic             win_end;
  logic [CNT_W-1:0] edge_next;
  logic             sat_next;

  // The window-end cycle folds its own edge into the closing window's result.
  assign win_end   = run && (gate_q == GATE_LAST);
  assign edge_next = rise ? inc_sat(edge_cnt_q) : edge_cnt_q;
  assign sat_next  = edge_sat_q | (rise & (edge_cnt_q == CNT_MAX));

  always_comb begin
    gate_d         = gate_q;
    edge_cnt_d     = edge_cnt_q;
    edge_sat_d     = edge_sat_q;
    per_cnt_d      = per_cnt_q;
    freq_d         = freq_q;
    freq_ovf_d     = freq_ovf_q;
    freq_valid_d   = 1'b0;
    period_d       = period_q;
    period_valid_d = 1'b0;

    if (!run) begin
      gate_d     = '0;
      edge_cnt_d = '0;
      edge_sat_d = 1'b0;
      per_cnt_d  = '0;
    end else begin
      gate_d = win_end ? '0 : gate_q + GW'(1);

      if (win_end) begin
        freq_d       = edge_next;
        freq_ovf_d   = sat_next;
        freq_valid_d = 1'b1;
        edge_cnt_d   = '0;
        edge_sat_d   = 1'b0;
      end else begin
        edge_cnt_d = edge_next;
        edge_sat_d = sat_next;
      end

      if (rise) begin
        per_cnt_d = '0;
        if (armed_q) begin
          period_d       = inc_sat(per_cnt_q);
          period_valid_d = 1'b1;
        end
      end else begin
        per_cnt_d = inc_sat(per_cnt_q);
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      gate_q         <= '0;
      edge_cnt_q     <= '0;
      edge_sat_q     <= 1'b0;
      per_cnt_q      <= '0;
      freq_q         <= '0;
      freq_ovf_q     <= 1'b0;
      freq_valid_q   <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      gate_q         <= gate_d;
      edge_cnt_q     <= edge_cnt_d;
      edge_sat_q     <= edge_sat_d;
      per_cnt_q      <= per_cnt_d;
      freq_q         <= freq_d;
      freq_ovf_q     <= freq_ovf_d;
      freq_valid_q   <= freq_valid_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign freq         = freq_q;
  assign freq_ovf     = freq_ovf_q;
  assign freq_valid   = freq_valid_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (8-bit and 5-bit counters) on shared
// stimulus, checked every cycle against a time-stamp based reference model.
module tb_freq_meter;

  localparam int G = 100;

  logic clk = 1'b0;
  logic rst_n, en, sig_in;

  logic [7:0] f8, p8;
  logic       fv8, ovf8, pv8;
  logic [4:0] f5, p5;
  logic       fv5, ovf5, pv5;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
    .clkin(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(f8), .freq_valid(fv8), .freq_ovf(ovf8),
    .period(p8), .period_valid(pv8)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(5)) dut5 (
    .clkin(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(f5), .freq_valid(fv5), .freq_ovf(ovf5),
    .period(p5), .period_valid(pv5)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Square-wave source: period per_v cycles, or man_sig when per_v is 0.
  int   per_v   = 0;
  logic man_sig = 1'b0;
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (per_v != 0) begin
        if (ph >= per_v) ph = 0;
        sig_in = (ph < per_v / 2);
        ph = (ph + 1 >= per_v) ? 0 : ph + 1;
      end else begin
        sig_in = man_sig;
      end
    end
  end

  // Reference model: edges become visible two clocks after being sampled;
  // results are derived from an unbounded edge tally and edge time stamps.
  int   mx[2] = '{255, 31};
  int   exp_freq[2], exp_per[2];
  bit   exp_fv[2], exp_ovf[2], exp_pv[2];
  bit   m_run, have_edge, h1, h2, h3;
  int   m_n, true_cnt, tick, last_t;

  initial begin
    bit e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; have_edge = 0; h1 = 0; h2 = 0; h3 = 0;
        m_n = 0; true_cnt = 0; last_t = 0;
        for (int i = 0; i < 2; i++) begin
          exp_freq[i] = 0; exp_per[i] = 0;
          exp_fv[i] = 0; exp_ovf[i] = 0; exp_pv[i] = 0;
        end
      end else begin
        e = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = sig_in;
        tick++;
        for (int i = 0; i < 2; i++) begin
          exp_fv[i] = 0; exp_pv[i] = 0;
        end
        if (m_run) begin
          if (e) true_cnt++;
          if ((m_n % G) == G - 1) begin
            for (int i = 0; i < 2; i++) begin
              exp_freq[i] = (true_cnt > mx[i]) ? mx[i] : true_cnt;
              exp_ovf[i]  = (true_cnt > mx[i]);
              exp_fv[i]   = 1;
            end
            true_cnt = 0;
          end
          if (e) begin
            if (have_edge)
              for (int i = 0; i < 2; i++) begin
                exp_per[i] = (tick - last_t > mx[i]) ? mx[i] : tick - last_t;
                exp_pv[i]  = 1;
              end
            last_t = tick;
            have_edge = 1;
          end
          m_n++;
          if (!en) m_run = 0;
        end else if (en) begin
          m_run = 1; m_n = 0; true_cnt = 0; have_edge = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("freq8",   int'(f8),   exp_freq[0]);
      chk("fvalid8", int'(fv8),  int'(exp_fv[0]));
      chk("ovf8",    int'(ovf8), int'(exp_ovf[0]));
      chk("period8", int'(p8),   exp_per[0]);
      chk("pvalid8", int'(pv8),  int'(exp_pv[0]));
      chk("freq5",   int'(f5),   exp_freq[1]);
      chk("fvalid5", int'(fv5),  int'(exp_fv[1]));
      chk("ovf5",    int'(ovf5), int'(exp_ovf[1]));
      chk("period5", int'(p5),   exp_per[1]);
      chk("pvalid5", int'(pv5),  int'(exp_pv[1]));
    end
  end

  task automatic wait_fv(input int budget, output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!fv8 && w < budget);
    chk("fv_seen", int'(fv8), 1);
  endtask

  initial begin
    int w, cnt;
    rst_n = 1'b1; en = 1'b0; per_v = 4;
    #1 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_freq", int'(f8), 0);
    chk("rst_fv", int'(fv8), 0);
    chk("rst_period", int'(p8), 0);
    chk("rst_pv", int'(pv8), 0);
    chk("rst_ovf", int'(ovf5), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Period-10 input, steady windows
    per_v = 10; en = 1'b1;
    wait_fv(150, w); wait_fv(150, w); wait_fv(150, w);
    chk("p10_interval", w, 100);
    chk("p10_freq", int'(f8), 10);
    chk("p10_ovf", int'(ovf8), 0);
    chk("p10_period", int'(p8), 10);
    @(negedge clk);
    chk("fv_one_cycle", int'(fv8), 0);

    // clkin/2 input saturates the 5-bit instance
    per_v = 2;
    wait_fv(150, w); wait_fv(150, w);
    chk("p2_freq5", int'(f5), 31);
    chk("p2_ovf5", int'(ovf5), 1);
    chk("p2_freq8", int'(f8), 50);
    chk("p2_ovf8", int'(ovf8), 0);
    per_v = 10;
    wait_fv(150, w); wait_fv(150, w);
    chk("back_freq5", int'(f5), 10);
    chk("back_ovf5", int'(ovf5), 0);

    // Single edge landing in the window-end cycle
    per_v = 0; man_sig = 1'b0;
    wait_fv(150, w); wait_fv(150, w);
    repeat (97) @(negedge clk);
    man_sig = 1'b1;
    repeat (3) @(negedge clk);
    chk("plant_fv", int'(fv8), 1);
    chk("plant_pv", int'(pv8), 1);
    chk("plant_freq", int'(f8), 1);
    chk("plant_per5_sat", int'(p5), 31);
    man_sig = 1'b0;
    wait_fv(150, w);
    chk("plant_next_freq", int'(f8), 0);
    chk("plant_next_interval", w, 100);

    // Abort a window at gate count 50
    per_v = 10;
    wait_fv(150, w);
    repeat (50) @(negedge clk);
    en = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(fv8);
    end
    chk("abort_no_fv", cnt, 0);
    en = 1'b1;
    wait_fv(150, w);
    chk("reentry_latency", w, 101);
    chk("reentry_freq", int'(f8), 10);

    // Asynchronous reset between clock edges
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_freq", int'(f8), 0);
    chk("arst_period", int'(p8), 0);
    chk("arst_fv", int'(fv8), 0);
    chk("arst_pv", int'(pv8), 0);
    chk("arst_ovf", int'(ovf8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fv(150, w);
    chk("post_reset_latency", w, 101);

    // Randomized segments
    for (int s = 0; s < 14; s++) begin
      per_v = ($urandom_range(0, 4) == 0) ? 2 : int'($urandom_range(3, 40));
      en    = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(40, 300)) @(negedge clk);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the frequency and period of an asynchronous square wave, such as the divided output of the team's clock generator or an external test pin, against the system clock. Over a fixed gate window of `GATE_CYCLES` system clocks it counts rising edges of `sig_in`. It also measures the edge-to-edge period in system clocks. Results sit on the display/readout path and are flagged with one-cycle valid strobes.

## Interface
Parameters:
- `GATE_CYCLES`, default 50000000: gate window length in `clkin` cycles (1 s at 50 MHz); must be ≥ 2.
- `CNT_W`, default 32: width of the frequency and period result counters.

Ports:
- `clkin` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `en` in 1: measurement enable (synchronous to `clkin`).
- `sig_in` in 1: measured signal, asynchronous to `clkin`.
- `freq` out CNT_W: rising edges counted in the last completed gate window.
- `freq_valid` out 1: one-cycle pulse when `freq` updates.
- `freq_ovf` out 1: the last window's edge count saturated.
- `period` out CNT_W: `clkin` cycles between the last two `sig_in` rising edges.
- `period_valid` out 1: one-cycle pulse when `period` updates.

## Operation
- Input path: `sig_in` passes through a 2-FF synchronizer, then a delay register. `edge` = sync & ~delayed.
- FSM states:
  - IDLE: `en`=0. Gate counter, edge counter and period counter are held at 0. Outputs hold their last values.
  - RUN: `en`=1.
- FSM transitions:
  - IDLE→RUN when `en`=1. The first window starts on the cycle after `en` is sampled high.
  - RUN→IDLE when `en`=0. Any partial window is discarded and produces no `freq_valid`.
- Gate counter: counts 0..GATE_CYCLES-1 in RUN, then wraps to 0. The cycle with count = GATE_CYCLES-1 is the window end.
- Edge counter:
  - Increments on `edge` in RUN and saturates at 2^CNT_W-1.
  - An edge in the window-end cycle belongs to the closing window.
- At window end:
  - `freq` ← edge count including the current-cycle edge.
  - `freq_ovf` ← saturation flag.
  - `freq_valid`=1 for one cycle.
  - Edge counter ← 0 and saturation flag ← 0.
- Period counter:
  - Counts `clkin` cycles in RUN and saturates at all-ones.
  - On `edge`, `period` ← count+1 (saturating), counter ← 0, and `period_valid`=1 for one cycle.
  - After entering RUN, the first edge only restarts the counter and does not strobe `period_valid`. The flag for this is held in the FSM.
- Width rule: all counters are unsigned CNT_W bits. No wrap-around on saturation; the value sticks at all-ones until cleared.

## Timing
- Reset values: `freq`=0, `freq_valid`=0, `freq_ovf`=0, `period`=0, `period_valid`=0. FSM=IDLE and the synchronizer registers are 0.
- Reset asserted mid-window clears all state immediately. No strobe is emitted.
- Latency: a `sig_in` rise meeting setup before `clkin` edge k produces `edge` high in cycle k+2.
- `sig_in` pulses narrower than one `clkin` period may be missed. Measurable input is ≤ `clkin`/2.
- `freq_valid` fires every GATE_CYCLES cycles while `en` stays high. The first pulse comes GATE_CYCLES cycles after RUN entry.
- Results update together with their valid strobes and hold until the next strobe.
- Simultaneous window end and `edge`: the edge is counted in the closing window. `freq_valid` and `period_valid` may pulse in the same cycle.
- `en` dropping in the window-end cycle: the window completes and its result is published; the next cycle is IDLE.

## Structure
- `freq_meter_pkg` holds:
  - The FSM state enum (IDLE, RUN).
  - The default GATE_CYCLES and CNT_W constants.
  - A saturating-increment function.
- Sub-module `sync_edge`: 2-FF synchronizer plus rising-edge detector, with `clkin`, `rst_n`, `d` and `rise` ports. It is reusable for other asynchronous inputs in the design.

## Test plan
Bench settings: GATE_CYCLES=100, CNT_W=8.
- Reset: hold `rst_n`=0 with `sig_in` toggling → all outputs 0 and no strobes.
- Period 10 input with `en`=1 → every 100 cycles `freq`=10 and `freq_valid` pulses one cycle. `period`=10 on each edge after the first, with `freq_ovf`=0.
- `sig_in` at `clkin`/2 (period 2) with CNT_W=5 → `freq`=31 and `freq_ovf`=1. Next window at period 10 → `freq`=10 and `freq_ovf`=0.
- Edge placed exactly in the window-end cycle → counted in the closing window. The next window's count excludes it, and both strobes coincide.
- `en` dropped at gate count 50 and re-raised → no `freq_valid` from the aborted window. The next `freq_valid` comes 100 cycles after re-entry, and the first post-entry edge gives no `period_valid`.
- `rst_n` asserted asynchronously mid-window (between clock edges) → outputs clear before the next `clkin` edge. After release, the first `freq_valid` comes a full window later.
